// File: rtl/arbitro_aleatorio_if.sv
// Request/grant bundle between the game processes and the shared random-number arbiter.
// The master side drives requests, ranges and the LFSR word; the slave side returns grants.
interface arbitro_aleatorio_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] limit;
  logic [31:0]         rand_in;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       data;
  logic                busy;

  modport master (
    output req, limit, rand_in,
    input  ack, data, busy
  );

  modport slave (
    input  req, limit, rand_in,
    output ack, data, busy
  );
endinterface

// File: rtl/arbitro_aleatorio.sv
// Round-robin arbiter handing out uniform values in [0, limit) from a shared LFSR word,
// using rejection sampling with a bounded-retry fallback and a minimum gap between samples.
module arbitro_aleatorio #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int GAP       = 8,
  parameter int MAX_TRIES = 4
) (
  input  logic                clk,
  input  logic                rst,
  arbitro_aleatorio_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Smear the MSB of (lim-1) downward; lim=0 wraps to all-ones, lim=1 gives zero.
  function automatic logic [DW-1:0] range_mask(input logic [DW-1:0] lim);
    logic [DW-1:0] m;
    m = lim - DW'(1);
    for (int s = 1; s < DW; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  function automatic logic [GW-1:0] gap_sat_inc(input logic [GW-1:0] g);
    return (g >= GW'(GAP)) ? GW'(GAP) : g + GW'(1);
  endfunction

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [DW-1:0]  lim_q, lim_d;
  logic [TW-1:0]  tries_q, tries_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [DW-1:0]  data_q, data_d;

  logic [DW-1:0]  lim_arr [N_REQ];
  logic [IW-1:0]  pick;
  logic           found;
  int             j;
  logic [DW-1:0]  cand;
  logic           gap_ok;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lim
    assign lim_arr[g] = bus.limit[g*DW +: DW];
  end

  if (DW < 32) begin : g_unused
    logic unused_rand_hi;
    assign unused_rand_hi = ^bus.rand_in[31:DW];
  end

  // Search starts just past the last winner so every requester is served within N_REQ grants.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && bus.req[IW'(j)]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign cand   = bus.rand_in[DW-1:0] & range_mask(lim_q);
  assign gap_ok = (gap_q >= GW'(GAP));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lim_d    = lim_q;
    tries_d  = tries_q;
    rr_ptr_d = rr_ptr_q;
    ack_d    = '0;
    data_d   = data_q;
    gap_d    = (state_q == S_SAMPLE) ? '0 : gap_sat_inc(gap_q);

    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d   = pick;
          lim_d   = lim_arr[pick];
          tries_d = '0;
          state_d = gap_ok ? S_SAMPLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.req[idx_q]) begin
          state_d = S_IDLE;
        end else if (gap_ok) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (!bus.req[idx_q]) begin
          state_d = S_IDLE;
        end else if ((lim_q == '0) || (cand < lim_q)) begin
          data_d        = cand;
          ack_d[idx_q]  = 1'b1;
          state_d       = S_DONE;
        end else if (tries_q == TW'(MAX_TRIES - 1)) begin
          // mask < 2*lim, so a rejected candidate minus lim always lands in range
          data_d        = cand - lim_q;
          ack_d[idx_q]  = 1'b1;
          state_d       = S_DONE;
        end else begin
          tries_d = tries_q + TW'(1);
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        rr_ptr_d = idx_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tries_q  <= '0;
      gap_q    <= '0;
      rr_ptr_q <= IW'(N_REQ - 1);
      ack_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      gap_q    <= gap_d;
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    lim_q <= lim_d;
  end

  assign bus.ack  = ack_q;
  assign bus.data = data_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_arbitro_aleatorio.sv
// Scoreboard bench for arbitro_aleatorio: expected grants are queued as stimulus is driven
// and matched against every ack pulse.
module tb_arbitro_aleatorio;
  localparam int N_REQ     = 4;
  localparam int DW        = 8;
  localparam int GAP       = 8;
  localparam int MAX_TRIES = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arbitro_aleatorio_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  arbitro_aleatorio #(
    .N_REQ(N_REQ), .DW(DW), .GAP(GAP), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int last_ack_cyc = 0;

  logic [DW-1:0] vals4 [5] = '{8'h11, 8'h5C, 8'hE7, 8'h03, 8'h9A};
  logic [DW-1:0] vals6 [3] = '{8'hFF, 8'h80, 8'h37};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.ack != '0) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_onehot", 32'(bus.ack), 32'(1) << e.idx);
        chk("data", 32'(bus.data), 32'(e.data));
      end
    end
  end

  task automatic wait_ack(input int max_c, output int at_cyc);
    int start;
    start  = ack_cnt;
    at_cyc = -1;
    for (int i = 0; i < max_c; i++) begin
      @(negedge clk);
      if (ack_cnt != start) begin
        at_cyc = last_ack_cyc;
        return;
      end
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, prev, rel, cnt;

    // 1: reset state and first grant with limit 0
    rst = 1'b1;
    bus.req     = 4'b0001;
    bus.limit   = '0;
    bus.rand_in = 32'h0000_00A5;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    sb.push_back('{idx: 0, data: 8'hA5});
    rst = 1'b0;
    rel = cyc;
    wait_ack(40, t);
    bus.req = '0;
    chk("t1_lat_ok", 32'((t - rel >= GAP + 2) && (t - rel <= GAP + 3)), 32'd1);
    repeat (GAP + 4) @(negedge clk);
    chk("t1_once", 32'(ack_cnt), 32'd1);

    // 2: first candidate rejected, second accepted
    bus.limit   = {8'd0, 8'd0, 8'd0, 8'd100};
    bus.rand_in = 32'h1234_56F0;
    sb.push_back('{idx: 0, data: 8'h2A});
    bus.req = 4'b0001;
    rel = cyc;
    @(negedge clk);
    @(negedge clk);
    bus.rand_in = 32'h1234_562A;
    wait_ack(60, t);
    bus.req = '0;
    chk("t2_gap_ok", 32'(t - rel >= GAP + 2), 32'd1);
    repeat (GAP + 4) @(negedge clk);

    // 3: every candidate rejected, fallback after MAX_TRIES samples
    cnt = ack_cnt;
    bus.rand_in = 32'hCAFE_007F;
    sb.push_back('{idx: 0, data: 8'd27});
    bus.req = 4'b0001;
    rel = cyc;
    wait_ack(120, t);
    bus.req = '0;
    chk("t3_tries_ok", 32'(t - rel >= (MAX_TRIES - 1) * GAP + 2), 32'd1);
    repeat (GAP + 4) @(negedge clk);
    chk("t3_one_ack", 32'(ack_cnt - cnt), 32'd1);

    // 4: all four requesting, round-robin order from reset
    pulse_reset();
    bus.limit   = '0;
    bus.rand_in = {24'hDEADBE, vals4[0]};
    sb.push_back('{idx: 0, data: vals4[0]});
    bus.req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(60, t);
      if (k > 0) chk("t4_spacing", 32'(t - prev >= GAP + 2), 32'd1);
      prev = t;
      if (k < 4) begin
        bus.rand_in = {24'hDEADBE, vals4[k+1]};
        sb.push_back('{idx: (k + 1) % N_REQ, data: vals4[k+1]});
      end else begin
        bus.req = 4'b0100;
      end
    end

    // 5a: abort during WAIT
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_wait", 32'(bus.busy), 32'd1);
    bus.req = '0;
    cnt = ack_cnt;
    @(negedge clk);
    chk("t5_busy_abort", 32'(bus.busy), 32'd0);
    repeat (GAP + 6) @(negedge clk);
    chk("t5_no_ack", 32'(ack_cnt), 32'(cnt));

    // 5b: reset during SAMPLE
    bus.rand_in = 32'h0000_003C;
    bus.req = 4'b0010;
    @(negedge clk);
    rst = 1'b1;
    bus.req = 4'b0011;
    @(negedge clk);
    chk("t5_rst_ack", 32'(bus.ack), 32'd0);
    chk("t5_rst_data", 32'(bus.data), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    sb.push_back('{idx: 0, data: 8'h3C});
    rst = 1'b0;
    wait_ack(40, t);
    bus.req = '0;

    // 6: limit 1 always yields zero
    bus.limit = {8'd0, 8'd0, 8'd1, 8'd0};
    for (int k = 0; k < 3; k++) begin
      repeat (GAP + 4) @(negedge clk);
      bus.rand_in = {24'h55AA33, vals6[k]};
      sb.push_back('{idx: 1, data: 8'd0});
      bus.req = 4'b0010;
      wait_ack(40, t);
      bus.req = '0;
    end

    repeat (GAP + 4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
